// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier round-robin arbiter.
// Holds the FSM encoding, default operand widths and the requester index width helper.
package mult_arb_pkg;

   localparam int unsigned A_BITS = 130;
   localparam int unsigned B_BITS = 128;
   localparam int unsigned P_BITS = A_BITS + B_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/mult_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches from rr_ptr upward with wrap and returns the first requester found.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index,
   output logic               any
);

   logic [IDX_W:0] pos;

   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      pos   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // Explicit wrap keeps non-power-of-2 requester counts correct
         pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(NUM_REQ)) begin
            pos = pos - (IDX_W+1)'(NUM_REQ);
         end
         if (!any && req[pos[IDX_W-1:0]]) begin
            any                   = 1'b1;
            index                 = pos[IDX_W-1:0];
            grant[pos[IDX_W-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one 130x128 limb multiplier between NUM_REQ requesters.
// Runs one job at a time with a watchdog that turns a lost mul_done into an error response.
module mult_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned A_BITS  = 130,
   parameter int unsigned B_BITS  = 128,
   parameter int unsigned P_BITS  = A_BITS + B_BITS,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*A_BITS-1:0]   req_a,
   input  logic [NUM_REQ*B_BITS-1:0]   req_b,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [P_BITS-1:0]           rsp_product,
   output logic                        rsp_err,
   output logic                        mul_start,
   output logic [A_BITS-1:0]           mul_a,
   output logic [B_BITS-1:0]           mul_b,
   input  logic                        mul_busy,
   input  logic                        mul_done,
   input  logic [P_BITS-1:0]           mul_product,
   output logic                        timeout_flag
);

   import mult_arb_pkg::*;

   localparam int unsigned IDX_W = idx_width(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_idx;
   logic [CNT_W-1:0]   wd_cnt;
   logic               wd_expired;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .grant  (pick_grant),
      .index  (pick_idx),
      .any    (pick_any)
   );

   assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      mul_start = 1'b0;
      unique case (state)
         S_IDLE: begin
            // Gated so req_ready stays low while reset is held
            req_ready = reset_n ? pick_grant : '0;
            if (pick_any) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            mul_start = !mul_busy;
            if (!mul_busy) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mul_done || wd_expired) state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid[grant_idx] = 1'b1;
            if (rsp_ready[grant_idx]) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr       <= '0;
         grant_idx    <= '0;
         wd_cnt       <= '0;
         mul_a        <= '0;
         mul_b        <= '0;
         rsp_product  <= '0;
         rsp_err      <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pick_any) begin
                  mul_a     <= req_a[pick_idx*A_BITS +: A_BITS];
                  mul_b     <= req_b[pick_idx*B_BITS +: B_BITS];
                  grant_idx <= pick_idx;
               end
            end
            S_ISSUE: begin
               wd_cnt <= '0;
            end
            S_WAIT: begin
               wd_cnt <= wd_cnt + CNT_W'(1);
               if (mul_done) begin
                  rsp_product <= mul_product;
                  rsp_err     <= 1'b0;
               end else if (wd_expired) begin
                  rsp_product  <= '0;
                  rsp_err      <= 1'b1;
                  timeout_flag <= 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready[grant_idx]) begin
                  rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter with a small latency-programmable multiplier model.
module tb_mult_rr_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned AB = 130;
   localparam int unsigned BB = 128;
   localparam int unsigned PB = 258;
   localparam int unsigned TO = 15;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR*AB-1:0]  req_a = '0;
   logic [NR*BB-1:0]  req_b = '0;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready = '0;
   logic [PB-1:0]     rsp_product;
   logic              rsp_err;
   logic              mul_start;
   logic [AB-1:0]     mul_a;
   logic [BB-1:0]     mul_b;
   logic              mul_busy;
   logic              mul_done;
   logic [PB-1:0]     mul_product;
   logic              timeout_flag;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mult_rr_arbiter #(
      .NUM_REQ (NR),
      .A_BITS  (AB),
      .B_BITS  (BB),
      .P_BITS  (PB),
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_product  (rsp_product),
      .rsp_err      (rsp_err),
      .mul_start    (mul_start),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_busy     (mul_busy),
      .mul_done     (mul_done),
      .mul_product  (mul_product),
      .timeout_flag (timeout_flag)
   );

   // Multiplier model: done pulses lat cycles after the start cycle, unless muted
   int unsigned   lat = 3;
   logic          mute = 1'b0;
   int unsigned   left;
   logic [PB-1:0] prod_q;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         left   <= 0;
         prod_q <= '0;
      end else if (mul_start) begin
         left   <= lat;
         prod_q <= PB'(mul_a) * PB'(mul_b);
      end else if (left != 0) begin
         left <= left - 1;
      end
   end

   assign mul_busy    = (left != 0);
   assign mul_done    = (left == 1) && !mute;
   assign mul_product = mul_done ? prod_q : '0;

   task automatic check(input string tag, input logic [PB-1:0] act, input logic [PB-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, PB'(req_ready), '0);
      check({tag, "_rsp_valid"}, PB'(rsp_valid), '0);
      check({tag, "_rsp_product"}, rsp_product, '0);
      check({tag, "_rsp_err"}, PB'(rsp_err), '0);
      check({tag, "_mul_start"}, PB'(mul_start), '0);
      check({tag, "_mul_a"}, PB'(mul_a), '0);
      check({tag, "_mul_b"}, PB'(mul_b), '0);
      check({tag, "_timeout_flag"}, PB'(timeout_flag), '0);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (rsp_valid == '0 && n < 200) begin
         tick();
         n++;
      end
   endtask

   // One job on requester k; exp_lat counts cycles from mul_start to rsp_valid
   task automatic do_job(input string tag, input int k, input logic [AB-1:0] a,
                         input logic [BB-1:0] b, input logic [PB-1:0] exp_p,
                         input logic exp_err, input int exp_lat);
      logic [NR-1:0] oh;
      int n;
      oh = '0;
      oh[k] = 1'b1;
      req_a[k*AB +: AB] = a;
      req_b[k*BB +: BB] = b;
      req_valid = oh;
      #1;
      check({tag, "_req_ready"}, PB'(req_ready), PB'(oh));
      tick();
      req_valid = '0;
      check({tag, "_mul_start"}, PB'(mul_start), PB'(1));
      check({tag, "_mul_a"}, PB'(mul_a), PB'(a));
      check({tag, "_mul_b"}, PB'(mul_b), PB'(b));
      wait_rsp(n);
      check({tag, "_latency"}, PB'(n), PB'(exp_lat));
      check({tag, "_rsp_valid"}, PB'(rsp_valid), PB'(oh));
      check({tag, "_product"}, rsp_product, exp_p);
      check({tag, "_err"}, PB'(rsp_err), PB'(exp_err));
      rsp_ready = oh;
      tick();
      rsp_ready = '0;
      check({tag, "_rsp_done"}, PB'(rsp_valid), '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [PB-1:0] big;
      logic [NR-1:0] oh;
      int n;
      int exp_k;

      req_valid = '1;
      repeat (2) tick();
      check_all_zero("rst");
      req_valid = '0;
      reset_n = 1'b1;
      tick();

      // Single small job on r0
      do_job("t1", 0, 130'd3, 128'd5, 258'd15, 1'b0, 4);

      // Full-width operands on r2: (2^130-1)*(2^128-1) = 2^258 - 2^130 - 2^128 + 1
      big = '0;
      big = big - (PB'(1) << 130) - (PB'(1) << 128) + PB'(1);
      do_job("t2", 2, '1, '1, big, 1'b0, 4);

      // Fresh reset so the rotation starts at r0
      reset_n = 1'b0;
      #1;
      check_all_zero("rst2");
      tick();
      reset_n = 1'b1;
      tick();

      // All requesters active, responses accepted immediately
      for (int k = 0; k < NR; k++) begin
         req_a[k*AB +: AB] = AB'(k + 1);
         req_b[k*BB +: BB] = BB'(10);
      end
      req_valid = '1;
      rsp_ready = '1;
      #1;
      for (int g = 0; g < 5; g++) begin
         exp_k = g % NR;
         oh = '0;
         oh[exp_k] = 1'b1;
         n = 0;
         while (req_ready == '0 && n < 100) begin
            tick();
            n++;
         end
         check("t3_grant", PB'(req_ready), PB'(oh));
         tick();
         wait_rsp(n);
         check("t3_rsp_valid", PB'(rsp_valid), PB'(oh));
         check("t3_product", rsp_product, PB'(10 * (exp_k + 1)));
         if (g == 4) req_valid = '0;
         tick();
      end
      rsp_ready = '0;

      // Response back-pressure on r3 while every requester keeps asking
      req_a[3*AB +: AB] = AB'(2);
      req_b[3*BB +: BB] = BB'(4);
      req_valid = 4'b1000;
      #1;
      check("t5_req_ready", PB'(req_ready), PB'(4'b1000));
      tick();
      req_valid = '1;
      wait_rsp(n);
      for (int c = 0; c < 20; c++) begin
         check("t5_rsp_valid", PB'(rsp_valid), PB'(4'b1000));
         check("t5_product", rsp_product, PB'(8));
         check("t5_err", PB'(rsp_err), '0);
         check("t5_req_ready", PB'(req_ready), '0);
         check("t5_mul_start", PB'(mul_start), '0);
         tick();
      end
      rsp_ready = 4'b0001;
      tick();
      check("t5_wrong_ready", PB'(rsp_valid), PB'(4'b1000));
      req_valid = '0;
      rsp_ready = 4'b1000;
      tick();
      rsp_ready = '0;
      check("t5_rsp_done", PB'(rsp_valid), '0);

      // Watchdog: done never arrives
      mute = 1'b1;
      do_job("t4_lost", 1, 130'd6, 128'd7, '0, 1'b1, 17);
      check("t4_flag", PB'(timeout_flag), PB'(1));
      mute = 1'b0;
      // Done on the very cycle the counter reaches TIMEOUT wins
      lat = 16;
      do_job("t4_edge", 0, 130'd11, 128'd13, 258'd143, 1'b0, 17);
      // Done one cycle late lands in RESP and is ignored
      lat = 17;
      do_job("t4_late", 2, 130'd5, 128'd5, '0, 1'b1, 17);
      check("t4_flag_sticky", PB'(timeout_flag), PB'(1));
      lat = 3;
      tick();

      // Reset during WAIT drops the job and clears the sticky flag
      req_a[0 +: AB] = AB'(4);
      req_b[0 +: BB] = BB'(4);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      reset_n = 1'b0;
      req_valid = '1;
      #1;
      check_all_zero("t6_rst");
      tick();
      check_all_zero("t6_rst_hold");
      req_valid = '0;
      reset_n = 1'b1;
      tick();
      do_job("t6_r1", 1, 130'd7, 128'd9, 258'd63, 1'b0, 4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
